// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2 SHA-256 message padder.
// Build option PBKDF2_PADDER_HMAC_OFFSET_EN (see pbkdf2_sha256_padder) adds a 512-bit HMAC offset to the length.
package pbkdf2_pkg;

    typedef enum logic [1:0] {
        DATA,
        PAD80,
        ZERO,
        LEN
    } pbkdf2_pad_state_e;

    localparam int unsigned SHA256_BLOCK_BYTES  = 64;
    localparam int unsigned SHA256_LEN_BYTES    = 8;
    localparam int unsigned SHA256_LEN_POS      = 56;
    localparam logic [7:0]  SHA256_PAD_BYTE     = 8'h80;
    localparam int unsigned HMAC_KEY_BLOCK_BITS = 512;

    localparam int unsigned SHA256_IDX_W = 6;
    localparam int unsigned SHA256_LEN_W = SHA256_LEN_BYTES * 8;

endpackage

// File: rtl/pbkdf2_len_shifter.sv
// 64-bit length register: parallel load, shift left by one byte, MSB byte presented.
module pbkdf2_len_shifter
    import pbkdf2_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [SHA256_LEN_W-1:0] load_val_i,
    input  logic                    shift_i,
    output logic [7:0]              msb_o
);

    logic [SHA256_LEN_W-1:0] len_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_r <= '0;
        end else if (load_i) begin
            len_r <= load_val_i;
        end else if (shift_i) begin
            len_r <= {len_r[SHA256_LEN_W-9:0], 8'h00};
        end
    end

    assign msb_o = len_r[SHA256_LEN_W-1 -: 8];

endmodule

// File: rtl/pbkdf2_sha256_padder.sv
// Byte-stream SHA-256 padder: message pass-through, 0x80, zero fill, 64-bit big-endian bit length.
// Define PBKDF2_PADDER_HMAC_OFFSET_EN to encode the length with an extra 512 bits for the HMAC key block.
module pbkdf2_sha256_padder
    import pbkdf2_pkg::*;
#(
    parameter int unsigned len_width_p = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       v_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic       v_o,
    output logic [7:0] data_o,
    output logic       block_last_o,
    output logic       msg_last_o,
    input  logic       yumi_i
);

    localparam logic [SHA256_IDX_W-1:0] LEN_IDX  = SHA256_IDX_W'(SHA256_LEN_POS);
    localparam logic [SHA256_IDX_W-1:0] ZERO_END = SHA256_IDX_W'(SHA256_LEN_POS - 1);
    localparam logic [SHA256_IDX_W-1:0] LAST_IDX = SHA256_IDX_W'(SHA256_BLOCK_BYTES - 1);

    pbkdf2_pad_state_e state_r, state_n;

    logic [SHA256_IDX_W-1:0] byte_idx_r;
    logic [SHA256_IDX_W-1:0] idx_inc;
    logic [len_width_p-1:0]  msg_len_r;
    logic [len_width_p-1:0]  msg_len_inc;
    logic [SHA256_LEN_W-1:0] len_load_val;
    logic [7:0]              len_byte;
    logic                    len_load;
    logic                    len_shift;
    logic                    fire;

    assign idx_inc     = byte_idx_r + SHA256_IDX_W'(1);
    assign msg_len_inc = msg_len_r + len_width_p'(1);
    assign fire        = v_o & yumi_i;

    // Length counts the byte being accepted now; it wraps with the message counter.
`ifdef PBKDF2_PADDER_HMAC_OFFSET_EN
    assign len_load_val = SHA256_LEN_W'({msg_len_inc, 3'b000}) + SHA256_LEN_W'(HMAC_KEY_BLOCK_BITS);
`else
    assign len_load_val = SHA256_LEN_W'({msg_len_inc, 3'b000});
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= DATA;
            byte_idx_r <= '0;
            msg_len_r  <= '0;
        end else begin
            state_r <= state_n;
            if (fire) begin
                byte_idx_r <= idx_inc;
                if (state_r == DATA) begin
                    msg_len_r <= msg_len_inc;
                end else if (state_r == LEN && byte_idx_r == LAST_IDX) begin
                    msg_len_r <= '0;
                end
            end
        end
    end

    always_comb begin
        state_n   = state_r;
        v_o       = 1'b0;
        data_o    = 8'h00;
        ready_o   = 1'b0;
        len_load  = 1'b0;
        len_shift = 1'b0;
        if (!reset_i) begin
            unique case (state_r)
                DATA: begin
                    v_o     = v_i;
                    data_o  = data_i;
                    ready_o = yumi_i;
                    if (v_i && yumi_i && last_i) begin
                        state_n  = PAD80;
                        len_load = 1'b1;
                    end
                end
                PAD80: begin
                    v_o    = 1'b1;
                    data_o = SHA256_PAD_BYTE;
                    // 0x80 at idx 56..63 leaves no room for the length: zeros spill into a new block.
                    if (yumi_i) begin
                        state_n = (idx_inc == LEN_IDX) ? LEN : ZERO;
                    end
                end
                ZERO: begin
                    v_o    = 1'b1;
                    data_o = 8'h00;
                    if (yumi_i && byte_idx_r == ZERO_END) begin
                        state_n = LEN;
                    end
                end
                LEN: begin
                    v_o    = 1'b1;
                    data_o = len_byte;
                    if (yumi_i) begin
                        len_shift = 1'b1;
                        if (byte_idx_r == LAST_IDX) begin
                            state_n = DATA;
                        end
                    end
                end
                default: state_n = DATA;
            endcase
        end
    end

    assign block_last_o = v_o & (byte_idx_r == LAST_IDX);
    assign msg_last_o   = v_o & (state_r == LEN) & (byte_idx_r == LAST_IDX);

    pbkdf2_len_shifter u_len_shifter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (len_load),
        .load_val_i (len_load_val),
        .shift_i    (len_shift),
        .msb_o      (len_byte)
    );

endmodule

// File: tb/tb_pbkdf2_sha256_padder.sv
// Directed bench for pbkdf2_sha256_padder: padded byte streams checked against hand-derived lengths.
module tb_pbkdf2_sha256_padder;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       v_i;
    logic [7:0] data_i;
    logic       last_i;
    logic       ready_o;
    logic       v_o;
    logic [7:0] data_o;
    logic       block_last_o;
    logic       msg_last_o;
    logic       yumi_i;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] msg_q[$];
    logic [7:0] exp_q[$];

`ifdef PBKDF2_PADDER_HMAC_OFFSET_EN
    localparam logic [63:0] LEN_3  = 64'h218;
    localparam logic [63:0] LEN_55 = 64'h3B8;
    localparam logic [63:0] LEN_56 = 64'h3C0;
    localparam logic [63:0] LEN_64 = 64'h400;
`else
    localparam logic [63:0] LEN_3  = 64'h018;
    localparam logic [63:0] LEN_55 = 64'h1B8;
    localparam logic [63:0] LEN_56 = 64'h1C0;
    localparam logic [63:0] LEN_64 = 64'h200;
`endif

    always #5 clk = ~clk;

    pbkdf2_sha256_padder dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .block_last_o (block_last_o),
        .msg_last_o   (msg_last_o),
        .yumi_i       (yumi_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Standard SHA-256 padding layout around a hand-supplied bit length.
    task automatic build_exp(input logic [63:0] len_bits);
        exp_q = msg_q;
        exp_q.push_back(8'h80);
        while (exp_q.size() % 64 != 56) exp_q.push_back(8'h00);
        for (int k = 7; k >= 0; k--) exp_q.push_back(len_bits[8*k +: 8]);
    endtask

    task automatic fill_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'(i + 1));
    endtask

    task automatic fill_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    // Drives msg_q as source, acts as sink with yumi every yumi_period cycles, checks every output byte.
    task automatic run_msg(input string name, input int yumi_period);
        int src = 0;
        int out = 0;
        int cyc = 0;
        while (out < exp_q.size() && cyc < 4000) begin
            v_i    = (src < msg_q.size());
            data_i = v_i ? msg_q[src] : 8'h00;
            last_i = v_i && (src == msg_q.size() - 1);
            yumi_i = (cyc % yumi_period) == 0;
            @(negedge clk);
            check({name, "_v"}, 64'(v_o), 64'd1);
            check({name, "_data"}, 64'(data_o), 64'(exp_q[out]));
            check({name, "_blast"}, 64'(block_last_o), 64'(out % 64 == 63));
            check({name, "_mlast"}, 64'(msg_last_o), 64'(out == exp_q.size() - 1));
            if (v_i) check({name, "_ready"}, 64'(ready_o), 64'(yumi_i));
            if (yumi_i) begin
                out++;
                if (src < msg_q.size()) src++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        if (out != exp_q.size()) check({name, "_timeout"}, 64'(out), 64'(exp_q.size()));
        v_i    = 1'b0;
        last_i = 1'b0;
        data_i = 8'h00;
        yumi_i = 1'b0;
        @(negedge clk);
        check({name, "_idle_v"}, 64'(v_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b1;
        data_i  = 8'h5A;
        last_i  = 1'b0;
        yumi_i  = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_v", 64'(v_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        @(negedge clk);
        check("post_rst_v", 64'(v_o), 64'd0);
        @(posedge clk);
        #1;

        fill_abc();
        build_exp(LEN_3);
        run_msg("abc", 1);

        fill_msg(55);
        build_exp(LEN_55);
        run_msg("m55", 1);

        fill_msg(56);
        build_exp(LEN_56);
        run_msg("m56", 1);

        fill_msg(64);
        build_exp(LEN_64);
        run_msg("m64", 1);

        fill_abc();
        build_exp(LEN_3);
        run_msg("abc_bp", 3);

        // Abandon a 30-byte message after 20 bytes, then a fresh "abc" must pad as if alone.
        fill_msg(30);
        for (int i = 0; i < 20; i++) begin
            v_i    = 1'b1;
            data_i = msg_q[i];
            last_i = 1'b0;
            yumi_i = 1'b1;
            @(negedge clk);
            check("part_data", 64'(data_o), 64'(msg_q[i]));
            @(posedge clk);
            #1;
        end
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_v", 64'(v_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        v_i     = 1'b0;
        yumi_i  = 1'b0;

        fill_abc();
        build_exp(LEN_3);
        run_msg("abc_after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
